// File: rtl/fpdiv_iter.sv
// fpdiv_iter: iterative radix-2 restoring floating-point divider (default bf16) with RNE rounding.
// Define FPDIV_FLAGS_EN to add the {invalid,divzero,overflow,underflow,inexact} flags port.
module fpdiv_iter #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 7,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready
`ifdef FPDIV_FLAGS_EN
  ,
  output logic [4:0]   flags
`endif
);

  localparam int QW   = MAN_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(QW);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;
  state_t state, state_nx;

  logic [EXP_W-1:0] x1_e, x2_e;
  logic [MAN_W-1:0] x1_m, x2_m;
  logic             x1_nan, x1_inf, x1_zero, x2_nan, x2_inf, x2_zero;
  logic             sp_nan, sp_inf, sp_zero;

  logic             sgn_q, nan_q, inf_q, zero_q;
  logic [EW-1:0]    e_q, e_r, nm_e;
  logic [MAN_W:0]   d_q, rnd_sum;
  logic [MAN_W+1:0] r_q, r_diff;
  logic             r_ge;
  logic [QW-1:0]    q_q;
  logic [CW-1:0]    cnt;
  logic             rnd_ph;
  logic [MAN_W-1:0] nm_m, m_r;
  logic             nm_g, nm_rb, nm_s, rnd_up, ovf, unf;
  logic [W-1:0]     y_pk;
`ifdef FPDIV_FLAGS_EN
  logic             sp_dz, dz_q, inx_r, spc;
`endif

  // Subnormals have a zero exponent field, so they classify as zero (flush).
  assign x1_e    = x1[W-2:MAN_W];
  assign x2_e    = x2[W-2:MAN_W];
  assign x1_m    = x1[MAN_W-1:0];
  assign x2_m    = x2[MAN_W-1:0];
  assign x1_nan  = (&x1_e) & (|x1_m);
  assign x1_inf  = (&x1_e) & ~(|x1_m);
  assign x1_zero = ~(|x1_e);
  assign x2_nan  = (&x2_e) & (|x2_m);
  assign x2_inf  = (&x2_e) & ~(|x2_m);
  assign x2_zero = ~(|x2_e);
  assign sp_nan  = x1_nan | x2_nan | (x1_zero & x2_zero) | (x1_inf & x2_inf);
  assign sp_inf  = ~sp_nan & (x1_inf | x2_zero);
  assign sp_zero = ~sp_nan & ~sp_inf & (x1_zero | x2_inf);
`ifdef FPDIV_FLAGS_EN
  assign sp_dz   = ~sp_nan & ~x1_inf & x2_zero;
`endif

  assign r_ge   = (r_q >= {1'b0, d_q});
  assign r_diff = r_ge ? (r_q - {1'b0, d_q}) : r_q;

  // Quotient MSB is the integer bit; when clear the result is in (0.5,1) and shifts up one.
  always_comb begin
    if (q_q[QW-1]) begin
      nm_m  = q_q[QW-2:3];
      nm_g  = q_q[2];
      nm_rb = q_q[1];
      nm_s  = q_q[0] | (|r_q);
      nm_e  = e_q;
    end else begin
      nm_m  = q_q[QW-3:2];
      nm_g  = q_q[1];
      nm_rb = q_q[0];
      nm_s  = |r_q;
      nm_e  = e_q - EW'(1);
    end
    rnd_up  = nm_g & (nm_rb | nm_s | nm_m[0]);
    rnd_sum = {1'b0, nm_m} + {{MAN_W{1'b0}}, rnd_up};
  end

  assign ovf = ~e_r[EW-1] & (e_r >= EMAX);
  assign unf = e_r[EW-1] | (e_r == '0);

  always_comb begin
    if (nan_q)       y_pk = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (inf_q)  y_pk = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (zero_q) y_pk = {sgn_q, {(W-1){1'b0}}};
    else if (ovf)    y_pk = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)    y_pk = {sgn_q, {(W-1){1'b0}}};
    else             y_pk = {sgn_q, e_r[EXP_W-1:0], m_r};
  end

`ifdef FPDIV_FLAGS_EN
  assign spc = nan_q | inf_q | zero_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = DIV;
      DIV:     if (cnt == CW'(QW - 1)) state_nx = ROUND;
      ROUND:   if (rnd_ph) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ROUND spends two cycles: normalise/round into e_r/m_r, then pack with special overrides.
  always_ff @(posedge clk) begin
    if (!rst) begin
      y      <= '0;
      cnt    <= '0;
      rnd_ph <= 1'b0;
`ifdef FPDIV_FLAGS_EN
      flags  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn_q  <= x1[W-1] ^ x2[W-1];
          nan_q  <= sp_nan;
          inf_q  <= sp_inf;
          zero_q <= sp_zero;
          e_q    <= {2'b00, x1_e} - {2'b00, x2_e} + EW'(BIAS);
          r_q    <= {2'b01, x1_m};
          d_q    <= {1'b1, x2_m};
          cnt    <= '0;
          rnd_ph <= 1'b0;
`ifdef FPDIV_FLAGS_EN
          dz_q   <= sp_dz;
`endif
        end
        DIV: begin
          r_q <= r_diff << 1;
          q_q <= {q_q[QW-2:0], r_ge};
          cnt <= cnt + CW'(1);
        end
        ROUND: if (!rnd_ph) begin
          rnd_ph <= 1'b1;
          m_r    <= rnd_sum[MAN_W-1:0];
          e_r    <= nm_e + EW'(rnd_sum[MAN_W]);
`ifdef FPDIV_FLAGS_EN
          inx_r  <= nm_g | nm_rb | nm_s;
`endif
        end else begin
          y <= y_pk;
`ifdef FPDIV_FLAGS_EN
          flags <= {nan_q, dz_q, ~spc & ovf, ~spc & unf, ~spc & (inx_r | ovf | unf)};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_iter.sv
// tb_fpdiv_iter: directed bf16 vectors, handshake/backpressure/reset checks, random vs real model.
module tb_fpdiv_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] x1, x2, y;
  logic        in_valid, in_ready, out_valid, out_ready;
`ifdef FPDIV_FLAGS_EN
  logic [4:0]  flags;
`endif
  int n_chk = 0;
  int n_err = 0;

  fpdiv_iter dut (
    .clk(clk), .rst(rst), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FPDIV_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    while (!in_ready && k < 50) begin @(posedge clk); #1; k++; end
    x1 = a; x2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x1 = 16'($urandom); x2 = 16'($urandom);
  endtask

  // Counts edges after the accept edge until out_valid; 40 means it never came.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ye, input logic [4:0] fe, input bit chk_fl);
    int lat;
    start_op(a, b);
    wait_out(lat);
    chk({tag, "_lat"}, lat, 13);
    chk({tag, "_y"}, y, ye);
`ifdef FPDIV_FLAGS_EN
    if (chk_fl) chk({tag, "_fl"}, flags, fe);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    real q, f, fr;
    int  e, i, eb;
    logic s;
    s = a[15] ^ b[15];
    q = real'(128 + int'(a[6:0])) / real'(128 + int'(b[6:0]));
    e = int'(a[14:7]) - int'(b[14:7]);
    while (q >= 2.0) begin q = q / 2.0; e++; end
    while (q < 1.0)  begin q = q * 2.0; e--; end
    f  = q * 128.0;
    i  = $rtoi(f);
    fr = f - real'(i);
    if (fr > 0.5 || (fr == 0.5 && (i % 2) == 1)) i++;
    if (i == 256) begin i = 128; e++; end
    eb = e + 127;
    if (eb >= 255) return {s, 8'hFF, 7'h00};
    if (eb <= 0)   return {s, 15'h0000};
    return {s, 8'(eb), 7'(i - 128)};
  endfunction

  initial begin
    int lat, seen;
    logic [15:0] a, b;
    in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 16'h0000);
`ifdef FPDIV_FLAGS_EN
    chk("rst_flags", flags, 0);
`endif
    rst = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);

    do_op("div8",   16'h41CD, 16'h404D, 16'h4100, 5'b00000, 1);
    do_op("neg8",   16'hC1CD, 16'h404D, 16'hC100, 5'b00000, 1);
    do_op("nn8",    16'hC1CD, 16'hC04D, 16'h4100, 5'b00000, 1);
    do_op("third",  16'h3F80, 16'h4040, 16'h3EAB, 5'b00001, 1);
    do_op("twelve", 16'h4140, 16'h3F00, 16'h41C0, 5'b00000, 1);
    do_op("divz",   16'h4080, 16'h0000, 16'h7F80, 5'b01000, 1);
    do_op("zdiv",   16'h0000, 16'h4060, 16'h0000, 5'b00000, 1);
    do_op("zz",     16'h0000, 16'h0000, 16'h7FC0, 5'b10000, 1);
    do_op("ovf",    16'h7F00, 16'h3E80, 16'h7F80, 5'b00101, 1);
    do_op("unf",    16'h0080, 16'h4000, 16'h0000, 5'b00011, 1);
    do_op("inf_f",  16'h7F80, 16'hC000, 16'hFF80, 5'b00000, 1);
    do_op("nan_in", 16'h7FC1, 16'h3F80, 16'h7FC0, 5'b10000, 1);
    do_op("subn",   16'h0001, 16'h3F80, 16'h0000, 5'b00000, 1);

    // Backpressure: result must hold and in_valid must be ignored while out_ready=0.
    start_op(16'h41CD, 16'h404D);
    wait_out(lat);
    chk("bp_lat", lat, 13);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0]; x1 = 16'h4140; x2 = 16'h3F00;
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, y}, {1'b1, 1'b0, 16'h4100});
    end
    in_valid = 1'b1; x1 = 16'h4140; x2 = 16'h3F00; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", in_ready, 0);
    wait_out(lat);
    chk("bp_next_lat", lat, 13);
    chk("bp_next_y", y, 16'h41C0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of DIV aborts the operation.
    start_op(16'h3F80, 16'h4040);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_out", seen, 0);
    chk("mid_rst_y", y, 16'h0000);
    do_op("after_rst", 16'h41CD, 16'h404D, 16'h4100, 5'b00000, 1);

    for (int n = 0; n < 1000; n++) begin
      a = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
      b = {1'($urandom), 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
      do_op("rnd", a, b, ref_div(a, b), 5'b00000, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
